// File: rtl/spi_sram_ctrl_if.sv
// Pin/strobe bundle between the SPI-to-SRAM sequencer and its datapath.
// The sequencer takes the slave modport; the datapath or bench takes the master modport.
interface spi_sram_ctrl_if;
  logic       CS_n;
  logic       done;
  logic [7:0] instr;
  logic       sram_ack;
  logic       count;
  logic       instrShift;
  logic       addrShift;
  logic       txShift;
  logic       load;
  logic       shift;
  logic       miso_oe;
  logic       sram_req;
  logic       sram_we;
  logic       addr_inc;
  logic       busy;
  logic       err;

  modport slave (
    input  CS_n, done, instr, sram_ack,
    output count, instrShift, addrShift, txShift, load, shift, miso_oe,
           sram_req, sram_we, addr_inc, busy, err
  );

  modport master (
    output CS_n, done, instr, sram_ack,
    input  count, instrShift, addrShift, txShift, load, shift, miso_oe,
           sram_req, sram_we, addr_inc, busy, err
  );
endinterface

// File: rtl/spi_sram_ctrl.sv
// Transaction sequencer for the SPI-to-SRAM datapath: walks opcode/address/data
// byte phases, runs the SRAM req/ack handshake with a timeout, and drives the strobes.
module spi_sram_ctrl #(
  parameter logic [7:0]  OP_READ     = 8'h03,
  parameter logic [7:0]  OP_WRITE    = 8'h02,
  parameter bit          SEQ_EN      = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic            SCK,
  input logic            rst_n,
  spi_sram_ctrl_if.slave bus
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] INSTR   = 4'd1;
  localparam logic [3:0] ADDR    = 4'd2;
  localparam logic [3:0] WR_DATA = 4'd3;
  localparam logic [3:0] WR_MEM  = 4'd4;
  localparam logic [3:0] RD_MEM  = 4'd5;
  localparam logic [3:0] RD_LOAD = 4'd6;
  localparam logic [3:0] RD_DATA = 4'd7;
  localparam logic [3:0] WAIT_CS = 4'd8;

  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       addr_inc_q, addr_inc_d;

  logic count_s, instr_shift_s, addr_shift_s, tx_shift_s;
  logic load_s, shift_s, miso_oe_s, sram_req_s, sram_we_s;
  logic cs_act;

  assign cs_act = !bus.CS_n;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    err_d      = err_q;
    tmo_d      = '0;
    addr_inc_d = 1'b0;
    if (state_q != IDLE && bus.CS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_act) begin
                   state_d = INSTR;
                   err_d   = 1'b0;
                 end
        INSTR:   if (bus.done) state_d = ADDR;
        ADDR:    if (bus.done) begin
                   if (bus.instr == OP_WRITE)     state_d = WR_DATA;
                   else if (bus.instr == OP_READ) state_d = RD_MEM;
                   else begin
                     state_d = WAIT_CS;
                     err_d   = 1'b1;
                   end
                 end
        WR_DATA: if (bus.done) state_d = WR_MEM;
        WR_MEM, RD_MEM: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (bus.sram_ack) begin
            if (state_q == RD_MEM) begin
              state_d = RD_LOAD;
            end else if (SEQ_EN) begin
              state_d    = WR_DATA;
              addr_inc_d = 1'b1;
            end else begin
              state_d = WAIT_CS;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = WAIT_CS;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
        RD_LOAD: state_d = RD_DATA;
        RD_DATA: if (bus.done) begin
                   if (SEQ_EN) begin
                     state_d    = RD_MEM;
                     addr_inc_d = 1'b1;
                   end else begin
                     state_d = WAIT_CS;
                   end
                 end
        WAIT_CS: state_d = WAIT_CS;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_s       = 1'b0;
    instr_shift_s = 1'b0;
    addr_shift_s  = 1'b0;
    tx_shift_s    = 1'b0;
    load_s        = 1'b0;
    shift_s       = 1'b0;
    miso_oe_s     = 1'b0;
    sram_req_s    = 1'b0;
    sram_we_s     = 1'b0;
    case (state_q)
      INSTR:   begin count_s = 1'b1; instr_shift_s = 1'b1; end
      ADDR:    begin count_s = 1'b1; addr_shift_s  = 1'b1; end
      WR_DATA: begin count_s = 1'b1; tx_shift_s    = 1'b1; end
      WR_MEM:  begin sram_req_s = 1'b1; sram_we_s = 1'b1; end
      RD_MEM:  sram_req_s = 1'b1;
      RD_LOAD: load_s = 1'b1;
      RD_DATA: begin count_s = 1'b1; shift_s = 1'b1; miso_oe_s = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge SCK) begin
    // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      addr_inc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      addr_inc_q <= addr_inc_d;
    end
  end

  // Raising CS_n silences every strobe in the same cycle.
  assign bus.count      = count_s       & cs_act;
  assign bus.instrShift = instr_shift_s & cs_act;
  assign bus.addrShift  = addr_shift_s  & cs_act;
  assign bus.txShift    = tx_shift_s    & cs_act;
  assign bus.load       = load_s        & cs_act;
  assign bus.shift      = shift_s       & cs_act;
  assign bus.miso_oe    = miso_oe_s     & cs_act;
  assign bus.sram_req   = sram_req_s    & cs_act;
  assign bus.sram_we    = sram_we_s     & cs_act;
  assign bus.addr_inc   = addr_inc_q    & cs_act;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench: a sequential (SEQ_EN=1) and a single-access (SEQ_EN=0) sequencer
// share one stimulus stream; expected strobe vectors are hand-derived per cycle.
module tb_spi_sram_ctrl;

  // Observation vector bit order:
  // {count, instrShift, addrShift, txShift, load, shift, miso_oe, sram_req, sram_we, addr_inc, busy, err}
  localparam logic [11:0] V_IDLE  = 12'h000;
  localparam logic [11:0] V_INSTR = 12'hC02;
  localparam logic [11:0] V_ADDR  = 12'hA02;
  localparam logic [11:0] V_WDATA = 12'h902;
  localparam logic [11:0] V_WMEM  = 12'h01A;
  localparam logic [11:0] V_RMEM  = 12'h012;
  localparam logic [11:0] V_RLOAD = 12'h082;
  localparam logic [11:0] V_RDATA = 12'h862;
  localparam logic [11:0] V_WAIT  = 12'h002;
  localparam logic [11:0] B_INC   = 12'h004;
  localparam logic [11:0] B_ERR   = 12'h001;

  logic       SCK = 1'b0;
  logic       rst_n;
  logic       cs_n, done, ack;
  logic [7:0] instr;

  int n_cmp = 0;
  int n_bad = 0;
  int inc_cnt = 0;
  int acc_cnt = 0;
  int inc0, acc0;

  always #5 SCK = ~SCK;

  spi_sram_ctrl_if seq_if ();
  spi_sram_ctrl_if sgl_if ();

  assign seq_if.CS_n = cs_n;  assign sgl_if.CS_n = cs_n;
  assign seq_if.done = done;  assign sgl_if.done = done;
  assign seq_if.instr = instr; assign sgl_if.instr = instr;
  assign seq_if.sram_ack = ack; assign sgl_if.sram_ack = ack;

  spi_sram_ctrl #(.SEQ_EN(1'b1)) u_seq (.SCK(SCK), .rst_n(rst_n), .bus(seq_if.slave));
  spi_sram_ctrl #(.SEQ_EN(1'b0)) u_sgl (.SCK(SCK), .rst_n(rst_n), .bus(sgl_if.slave));

  logic [11:0] seq_obs, sgl_obs;
  assign seq_obs = {seq_if.count, seq_if.instrShift, seq_if.addrShift, seq_if.txShift,
                    seq_if.load, seq_if.shift, seq_if.miso_oe, seq_if.sram_req,
                    seq_if.sram_we, seq_if.addr_inc, seq_if.busy, seq_if.err};
  assign sgl_obs = {sgl_if.count, sgl_if.instrShift, sgl_if.addrShift, sgl_if.txShift,
                    sgl_if.load, sgl_if.shift, sgl_if.miso_oe, sgl_if.sram_req,
                    sgl_if.sram_we, sgl_if.addr_inc, sgl_if.busy, sgl_if.err};

  // Free-running event counters on the sequential instance, sampled mid-cycle.
  always @(negedge SCK) begin
    if (seq_if.addr_inc) inc_cnt++;
    if (seq_if.sram_req && seq_if.sram_ack) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCK);
    #1;
  endtask

  // Check both instances in the current cycle, then advance one SCK.
  task automatic cyc(input string tag, input logic [11:0] e_seq, input logic [11:0] e_sgl);
    #1;
    check({tag, "/seq"}, 32'(seq_obs), 32'(e_seq));
    check({tag, "/sgl"}, 32'(sgl_obs), 32'(e_sgl));
    tick();
  endtask

  task automatic phase(input string tag, input logic [11:0] e_seq, input logic [11:0] e_sgl);
    for (int i = 0; i < 8; i++) begin
      done = (i == 7);
      cyc(tag, e_seq, e_sgl);
    end
    done = 1'b0;
  endtask

  task automatic start(input logic [7:0] op, input logic [11:0] e_idle);
    cs_n = 1'b0;
    cyc("start_idle", e_idle, e_idle);
    phase("instr", V_INSTR, V_INSTR);
    instr = op;
    phase("addr", V_ADDR, V_ADDR);
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; done = 1'b0; ack = 1'b0; instr = 8'h00;
    tick(); tick();
    cyc("reset", V_IDLE, V_IDLE);
    rst_n = 1'b1;
    cyc("idle", V_IDLE, V_IDLE);

    // Single write with ack after two wait cycles
    acc0 = acc_cnt;
    start(8'h02, V_IDLE);
    phase("wr_data", V_WDATA, V_WDATA);
    cyc("wr_mem0", V_WMEM, V_WMEM);
    cyc("wr_mem1", V_WMEM, V_WMEM);
    ack = 1'b1;
    cyc("wr_mem_ack", V_WMEM, V_WMEM);
    ack = 1'b0;
    cyc("wr_after", V_WDATA | B_INC, V_WAIT);
    check("wr_accesses", 32'(acc_cnt - acc0), 32'd1);
    cs_n = 1'b1;
    cyc("wr_csup", V_WAIT, V_WAIT);
    cyc("wr_idle", V_IDLE, V_IDLE);

    // Single read with ack after one wait cycle
    start(8'h03, V_IDLE);
    cyc("rd_mem0", V_RMEM, V_RMEM);
    ack = 1'b1;
    cyc("rd_mem_ack", V_RMEM, V_RMEM);
    ack = 1'b0;
    cyc("rd_load", V_RLOAD, V_RLOAD);
    phase("rd_data", V_RDATA, V_RDATA);
    cyc("rd_after", V_RMEM | B_INC, V_WAIT);
    cs_n = 1'b1;
    cyc("rd_csup", V_WAIT, V_WAIT);
    cyc("rd_idle", V_IDLE, V_IDLE);

    // Sequential read of three bytes; the single instance parks in WAIT_CS
    inc0 = inc_cnt; acc0 = acc_cnt;
    start(8'h03, V_IDLE);
    for (int b = 0; b < 3; b++) begin
      ack = 1'b1;
      cyc("sq_mem", (b == 0) ? V_RMEM : (V_RMEM | B_INC), (b == 0) ? V_RMEM : V_WAIT);
      ack = 1'b0;
      cyc("sq_load", V_RLOAD, (b == 0) ? V_RLOAD : V_WAIT);
      phase("sq_data", V_RDATA, (b == 0) ? V_RDATA : V_WAIT);
    end
    check("sq_inc_instream", 32'(inc_cnt - inc0), 32'd2);
    check("sq_reads", 32'(acc_cnt - acc0), 32'd3);
    cyc("sq_tail", V_RMEM | B_INC, V_WAIT);
    check("sq_inc_total", 32'(inc_cnt - inc0), 32'd3);
    cs_n = 1'b1;
    cyc("sq_csup", V_WAIT, V_WAIT);
    cyc("sq_idle", V_IDLE, V_IDLE);

    // Bad opcode: error, no SRAM access, cleared by the next CS_n fall
    acc0 = acc_cnt;
    start(8'hFF, V_IDLE);
    cyc("bad_wait0", V_WAIT | B_ERR, V_WAIT | B_ERR);
    cyc("bad_wait1", V_WAIT | B_ERR, V_WAIT | B_ERR);
    check("bad_no_access", 32'(acc_cnt - acc0), 32'd0);
    cs_n = 1'b1;
    cyc("bad_csup", V_WAIT | B_ERR, V_WAIT | B_ERR);
    cyc("bad_idle", B_ERR, B_ERR);
    cs_n = 1'b0;
    cyc("bad_idle_cs", B_ERR, B_ERR);
    cyc("bad_clr", V_INSTR, V_INSTR);

    // Abort mid-ADDR
    phase("ab_instr", V_INSTR, V_INSTR);
    instr = 8'h03;
    cyc("ab_addr0", V_ADDR, V_ADDR);
    cyc("ab_addr1", V_ADDR, V_ADDR);
    cs_n = 1'b1;
    cyc("ab_csup", V_WAIT, V_WAIT);
    cyc("ab_idle", V_IDLE, V_IDLE);
    ack = 1'b1;
    cyc("late_ack", V_IDLE, V_IDLE);
    ack = 1'b0;
    cyc("late_ack_idle", V_IDLE, V_IDLE);

    // Ack timeout: sram_req held 15 cycles, then error
    start(8'h03, V_IDLE);
    for (int i = 0; i < 15; i++) cyc("to_mem", V_RMEM, V_RMEM);
    cyc("to_wait", V_WAIT | B_ERR, V_WAIT | B_ERR);
    cs_n = 1'b1;
    cyc("to_csup", V_WAIT | B_ERR, V_WAIT | B_ERR);
    cyc("to_idle", B_ERR, B_ERR);

    // Ack on the final timeout cycle wins
    start(8'h03, B_ERR);
    for (int i = 0; i < 14; i++) cyc("lim_mem", V_RMEM, V_RMEM);
    ack = 1'b1;
    cyc("lim_ack", V_RMEM, V_RMEM);
    ack = 1'b0;
    cyc("lim_load", V_RLOAD, V_RLOAD);
    cs_n = 1'b1;
    cyc("lim_csup", V_WAIT, V_WAIT);
    cyc("lim_idle", V_IDLE, V_IDLE);

    // Reset during RD_MEM with CS_n low and ack high
    start(8'h03, V_IDLE);
    cyc("rs_mem", V_RMEM, V_RMEM);
    rst_n = 1'b0; ack = 1'b1;
    cyc("rs_mem_rst", V_RMEM, V_RMEM);
    ack = 1'b0;
    cyc("rs_reset", V_IDLE, V_IDLE);
    rst_n = 1'b1;
    cyc("rs_release", V_IDLE, V_IDLE);
    cyc("rs_instr", V_INSTR, V_INSTR);
    cs_n = 1'b1;
    cyc("rs_csup", V_WAIT, V_WAIT);
    cyc("rs_idle", V_IDLE, V_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
